pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the active-low `en_n` hold input and a synchronous flush of each inter-stage `delay` register (IF/ID, ID/EX, EX/MEM, MEM/WB) and of the PC register. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and sequences multi-cycle freezes for data-memory wait states and the iterative mul/div unit. It sits beside the datapath and has no data path of its own.

## Interface
- `REG_ADDR_W`, 5, register-file address width
- `MULDIV_CYCLES`, 32, total EX occupancy of one mul/div operation, ≥2
- `MEM_TIMEOUT`, 255, maximum MEM_WAIT cycles before abort, ≥1
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_rs`, `id_rt`  in  REG_ADDR_W  source registers of the instruction in ID
- `id_use_rt`  in  1  ID instruction reads `rt`
- `id_jump`  in  1  ID holds a jump (J/JAL/JR)
- `ex_mem_read`  in  1  EX holds a load
- `ex_rd`  in  REG_ADDR_W  EX destination register
- `ex_branch_taken`  in  1  EX resolved a taken branch
- `ex_muldiv_start`  in  1  EX issues a mul/div
- `mem_req`  in  1  MEM stage accesses data memory this cycle
- `dmem_ready`  in  1  data memory completes this cycle
- `pc_en_n`, `ifid_en_n`, `idex_en_n`, `exmem_en_n`, `memwb_en_n`  out  1 each  1 = hold the register
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  1 = load a bubble (all-zero control) on the next edge
- `mem_timeout`  out  1  one-cycle pulse on a MEM_WAIT abort
- `busy`  out  1  state ≠ RUN

## Operation
- FSM states: RUN, MEM_WAIT, MULDIV.
- Outputs are Mealy: combinational from state and current inputs. `mem_timeout` is registered.
- Hazard terms:
  - load-use = `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs` | (`id_use_rt` & `ex_rd`==`id_rt`)).
  - mem-stall = `mem_req` & !`dmem_ready`.
- Priority, highest first: mem-stall/MEM_WAIT > MULDIV > branch > load-use > jump.
- RUN, no event: all `en_n`=0, all flush=0.
- RUN, mem-stall: `pc`, `ifid`, `idex`, `exmem` `en_n`=1; `memwb_flush`=1. Next state MEM_WAIT, wait counter cleared to 0.
- RUN, `ex_muldiv_start`: `pc`, `ifid`, `idex` `en_n`=1; `exmem_flush`=1. Next state MULDIV, counter loaded with MULDIV_CYCLES-2.
- RUN, branch taken: `ifid_flush`=1, `idex_flush`=1. Load-use and jump are ignored, because the ID instruction is squashed.
- RUN, load-use: `pc_en_n`=1, `ifid_en_n`=1, `idex_flush`=1 for exactly one cycle. The hazard clears once the load advances.
- RUN, `id_jump` with no higher event: `ifid_flush`=1.
- MEM_WAIT:
  - Freeze outputs are the same as on entry.
  - `dmem_ready`=1 → RUN. That cycle all `en_n`=0; the completing load/store advances.
  - Counter reaches MEM_TIMEOUT → RUN with a `mem_timeout` pulse next cycle. The aborted MEM instruction is bubbled via `memwb_flush`=1.
- MULDIV:
  - Freeze outputs are the same as on entry.
  - Counter decrements each cycle; counter==0 → RUN.
  - If a mem-stall arises while in MULDIV, it additionally holds `exmem`/`memwb` per the MEM_WAIT rule. The MULDIV counter keeps running. MEM_WAIT is entered only when MULDIV exits with the stall still present.
- Counters:
  - Wait counter width = clog2(MEM_TIMEOUT+1), saturating.
  - MULDIV counter width = clog2(MULDIV_CYCLES).
  - No wrap permitted.

## Timing
- Reset, while `rst`=1:
  - State RUN, counters 0.
  - All `en_n`=1 and all flush=1, so the pipeline fills with bubbles.
  - `mem_timeout`=0, `busy`=0.
- Reset mid-MEM_WAIT or mid-MULDIV aborts to RUN on the same edge.
- Load-use stall costs exactly 1 cycle. Taken branch costs 2 bubbles. Jump costs 1 bubble.
- A mul/div occupies EX for MULDIV_CYCLES cycles including the issue cycle; the dependent ID instruction advances in the cycle after exit.
- MEM_WAIT lasts N cycles for `dmem_ready` arriving N cycles after the request; `dmem_ready` in the request cycle causes no stall.
- `busy` goes high the cycle after entry and goes low the cycle after exit.

## Structure
- `pipe_ctrl_pkg`: state enum {RUN, MEM_WAIT, MULDIV}, and a stage-index localparam set (PC, IFID, IDEX, EXMEM, MEMWB) used to pack the `en_n`/flush vectors.
- Sub-module `hazard_detect`: pure combinational load-use/branch/jump decode. The FSM and counters live in `pipe_ctrl`.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8 → one cycle of `pc_en_n`=`ifid_en_n`=1, `idex_flush`=1. With `ex_rd`=0 → no stall.
- Branch + load-use in the same cycle → `ifid_flush`=`idex_flush`=1, `pc_en_n`=0 (branch wins).
- `mem_req`=1 with `dmem_ready` arriving 3 cycles later → 3 frozen cycles with `memwb_flush`=1, `busy`=1, then all `en_n`=0.
- MEM_TIMEOUT=4, `dmem_ready` never asserted → exit after 4 cycles, `mem_timeout` pulses once.
- MULDIV_CYCLES=4, `ex_muldiv_start` → PC/IFID/IDEX held 3 cycles, `exmem_flush`=1 each cycle. A mem-stall injected in cycle 2 extends the freeze per the priority rules.
- `rst` asserted mid-MULDIV → next cycle state RUN, `busy`=0, all outputs at reset values.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and the
// stage indices used to pack the hold/flush vectors.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2
    } state_t;

    // Bit positions of each pipeline register in the packed en_n/flush vectors.
    // The PC has a hold but no bubble, so the flush vector starts at IFID.
    localparam int STG_PC     = 0;
    localparam int STG_IFID   = 1;
    localparam int STG_IDEX   = 2;
    localparam int STG_EXMEM  = 3;
    localparam int STG_MEMWB  = 4;
    localparam int NUM_STAGES = 5;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational decode of the in-order hazards seen from ID/EX: taken-branch
// squash, load-use stall and jump bubble, already resolved against each other
// so at most one of the three is asserted.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rt,
    input  logic                  id_jump,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    output logic                  squash,
    output logic                  load_use_stall,
    output logic                  jump_bubble
);

    logic rs_match;
    logic rt_match;
    logic load_use;

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign rs_match = (ex_rd == id_rs);
    assign rt_match = id_use_rt && (ex_rd == id_rt);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs_match || rt_match);

    // A taken branch kills the ID instruction, making its hazards irrelevant.
    assign squash         = ex_branch_taken;
    assign load_use_stall = load_use && !ex_branch_taken;
    assign jump_bubble    = id_jump && !ex_branch_taken && !load_use;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Hold and flush
// outputs are Mealy (state + current inputs); mem_timeout is registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int MULDIV_CYCLES = 32,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rt,
    input  logic                  id_jump,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  ex_muldiv_start,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en_n,
    output logic                  ifid_en_n,
    output logic                  idex_en_n,
    output logic                  exmem_en_n,
    output logic                  memwb_en_n,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  mem_timeout,
    output logic                  busy
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int MD_W   = $clog2(MULDIV_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [MD_W-1:0]   MD_LOAD  = MD_W'(MULDIV_CYCLES - 2);

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next, wait_sat;
    logic [MD_W-1:0]     md_cnt_reg, md_cnt_next;
    logic                mem_timeout_reg, mem_timeout_next;
    logic [NUM_STAGES-1:0]      en_n_vec;
    logic [STG_MEMWB:STG_IFID]  flush_vec;

    logic mem_stall;
    logic squash;
    logic load_use_stall;
    logic jump_bubble;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rt       (id_use_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .squash          (squash),
        .load_use_stall  (load_use_stall),
        .jump_bubble     (jump_bubble)
    );

    assign mem_stall = mem_req && !dmem_ready;
    assign wait_sat  = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + WAIT_W'(1);

    // Next-state, counter and hold/flush decode; priority mem > muldiv > branch > load-use > jump.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        md_cnt_next      = md_cnt_reg;
        mem_timeout_next = 1'b0;
        en_n_vec         = '0;
        flush_vec        = '0;
        if (rst) begin
            en_n_vec      = '1;
            flush_vec     = '1;
            state_next    = RUN;
            wait_cnt_next = '0;
            md_cnt_next   = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        en_n_vec[STG_PC]     = 1'b1;
                        en_n_vec[STG_IFID]   = 1'b1;
                        en_n_vec[STG_IDEX]   = 1'b1;
                        en_n_vec[STG_EXMEM]  = 1'b1;
                        flush_vec[STG_MEMWB] = 1'b1;
                        state_next           = MEM_WAIT;
                        wait_cnt_next        = '0;
                    end else if (ex_muldiv_start) begin
                        en_n_vec[STG_PC]     = 1'b1;
                        en_n_vec[STG_IFID]   = 1'b1;
                        en_n_vec[STG_IDEX]   = 1'b1;
                        flush_vec[STG_EXMEM] = 1'b1;
                        state_next           = MULDIV;
                        md_cnt_next          = MD_LOAD;
                    end else if (squash) begin
                        flush_vec[STG_IFID] = 1'b1;
                        flush_vec[STG_IDEX] = 1'b1;
                    end else if (load_use_stall) begin
                        en_n_vec[STG_PC]    = 1'b1;
                        en_n_vec[STG_IFID]  = 1'b1;
                        flush_vec[STG_IDEX] = 1'b1;
                    end else if (jump_bubble) begin
                        flush_vec[STG_IFID] = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        // Completing access: everything advances this cycle.
                        state_next = RUN;
                    end else if (wait_sat == WAIT_MAX) begin
                        // Abort: drop the stuck MEM instruction and let the rest advance.
                        flush_vec[STG_MEMWB] = 1'b1;
                        state_next           = RUN;
                        wait_cnt_next        = wait_sat;
                        mem_timeout_next     = 1'b1;
                    end else begin
                        en_n_vec[STG_PC]     = 1'b1;
                        en_n_vec[STG_IFID]   = 1'b1;
                        en_n_vec[STG_IDEX]   = 1'b1;
                        en_n_vec[STG_EXMEM]  = 1'b1;
                        flush_vec[STG_MEMWB] = 1'b1;
                        wait_cnt_next        = wait_sat;
                    end
                end
                MULDIV: begin
                    en_n_vec[STG_PC]   = 1'b1;
                    en_n_vec[STG_IFID] = 1'b1;
                    en_n_vec[STG_IDEX] = 1'b1;
                    if (mem_stall) begin
                        // The instruction in MEM must be kept, so hold EX/MEM instead of bubbling it.
                        en_n_vec[STG_EXMEM]  = 1'b1;
                        flush_vec[STG_MEMWB] = 1'b1;
                    end else begin
                        flush_vec[STG_EXMEM] = 1'b1;
                    end
                    if (md_cnt_reg == '0) begin
                        state_next    = mem_stall ? MEM_WAIT : RUN;
                        wait_cnt_next = '0;
                    end else begin
                        md_cnt_next = md_cnt_reg - MD_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State, counters and the registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            md_cnt_reg      <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            md_cnt_reg      <= md_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    assign pc_en_n     = en_n_vec[STG_PC];
    assign ifid_en_n   = en_n_vec[STG_IFID];
    assign idex_en_n   = en_n_vec[STG_IDEX];
    assign exmem_en_n  = en_n_vec[STG_EXMEM];
    assign memwb_en_n  = en_n_vec[STG_MEMWB];
    assign ifid_flush  = flush_vec[STG_IFID];
    assign idex_flush  = flush_vec[STG_IDEX];
    assign exmem_flush = flush_vec[STG_EXMEM];
    assign memwb_flush = flush_vec[STG_MEMWB];

    // Status outputs read as idle while reset is held.
    assign mem_timeout = mem_timeout_reg && !rst;
    assign busy        = (state_reg != RUN) && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard sequences followed by random
// traffic, each cycle predicted by a rule-level model and checked by a monitor.
module tb_pipe_ctrl;

    localparam int AW  = 5;
    localparam int MDC = 4;
    localparam int MTO = 4;

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] id_rs;
        logic [AW-1:0] id_rt;
        logic          id_use_rt;
        logic          id_jump;
        logic          ex_mem_read;
        logic [AW-1:0] ex_rd;
        logic          ex_branch_taken;
        logic          ex_muldiv_start;
        logic          mem_req;
        logic          dmem_ready;
    } stim_t;

    // en_n = {pc,ifid,idex,exmem,memwb}, flush = {ifid,idex,exmem,memwb}
    typedef struct packed {
        logic [4:0] en_n;
        logic [3:0] flush;
        logic       busy;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_use_rt = 0, id_jump = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic ex_muldiv_start = 0, mem_req = 0, dmem_ready = 0;
    logic pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout, busy;

    pipe_ctrl #(
        .REG_ADDR_W    (AW),
        .MULDIV_CYCLES (MDC),
        .MEM_TIMEOUT   (MTO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rt       (id_use_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_en_n         (pc_en_n),
        .ifid_en_n       (ifid_en_n),
        .idex_en_n       (idex_en_n),
        .exmem_en_n      (exmem_en_n),
        .memwb_en_n      (memwb_en_n),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .mem_timeout     (mem_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: elapsed memory-wait cycles (-1 = not waiting),
    // remaining mul/div freeze cycles after issue, and a pending timeout pulse.
    int mw_elapsed = -1;
    int md_left    = 0;
    bit tmo_flag   = 0;

    task automatic step(input stim_t s);
        exp_t e;
        int   nmw;
        int   nmd;
        bit   ntmo;
        bit   lu;
        bit   st;
        @(posedge clk);
        #1;
        rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_use_rt = s.id_use_rt;
        id_jump = s.id_jump; ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd;
        ex_branch_taken = s.ex_branch_taken; ex_muldiv_start = s.ex_muldiv_start;
        mem_req = s.mem_req; dmem_ready = s.dmem_ready;
        e = '0; nmw = mw_elapsed; nmd = md_left; ntmo = 0;
        lu = s.ex_mem_read && (s.ex_rd != 0) &&
             ((s.ex_rd == s.id_rs) || (s.id_use_rt && (s.ex_rd == s.id_rt)));
        st = s.mem_req && !s.dmem_ready;
        if (s.rst) begin
            e.en_n = 5'b11111; e.flush = 4'b1111; nmw = -1; nmd = 0;
        end else begin
            e.busy = (mw_elapsed >= 0) || (md_left > 0);
            e.tmo  = tmo_flag;
            if (mw_elapsed >= 0) begin
                if (s.dmem_ready) begin
                    nmw = -1;
                end else if (mw_elapsed + 1 >= MTO) begin
                    e.flush = 4'b0001; nmw = -1; ntmo = 1;
                end else begin
                    e.en_n = 5'b11110; e.flush = 4'b0001; nmw = mw_elapsed + 1;
                end
            end else if (md_left > 0) begin
                e.en_n = 5'b11100;
                if (st) begin e.en_n[1] = 1'b1; e.flush = 4'b0001; end
                else        e.flush = 4'b0010;
                nmd = md_left - 1;
                if (nmd == 0 && st) nmw = 0;
            end else if (st) begin
                e.en_n = 5'b11110; e.flush = 4'b0001; nmw = 0;
            end else if (s.ex_muldiv_start) begin
                e.en_n = 5'b11100; e.flush = 4'b0010; nmd = MDC - 1;
            end else if (s.ex_branch_taken) begin
                e.flush = 4'b1100;
            end else if (lu) begin
                e.en_n = 5'b11000; e.flush = 4'b0100;
            end else if (s.id_jump) begin
                e.flush = 4'b1000;
            end
        end
        mw_elapsed = nmw; md_left = nmd; tmo_flag = ntmo;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
    exp_t mon_exp, mon_got;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = {pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n,
                           ifid_flush, idex_flush, exmem_flush, memwb_flush, busy, mem_timeout};
                checks++;
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL cyc%0d outputs got en_n=%b flush=%b busy=%b tmo=%b exp en_n=%b flush=%b busy=%b tmo=%b",
                             cyc, mon_got.en_n, mon_got.flush, mon_got.busy, mon_got.tmo,
                             mon_exp.en_n, mon_exp.flush, mon_exp.busy, mon_exp.tmo);
                end else begin
                    $display("cyc%0d en_n=%b flush=%b busy=%b tmo=%b ok",
                             cyc, mon_got.en_n, mon_got.flush, mon_got.busy, mon_got.tmo);
                end
                cyc++;
            end
        end
    end

    initial begin
        stim_t s;
        // reset
        s = '0; s.rst = 1; step(s); step(s);
        s = '0; step(s);
        // load-use on rs, then the load advances
        s = '0; s.ex_mem_read = 1; s.ex_rd = 8; s.id_rs = 8; step(s);
        s.ex_mem_read = 0; step(s);
        // load to r0 is not a hazard
        s = '0; s.ex_mem_read = 1; s.ex_rd = 0; s.id_rs = 0; step(s);
        // branch beats load-use
        s = '0; s.ex_branch_taken = 1; s.ex_mem_read = 1; s.ex_rd = 8; s.id_rs = 8; step(s);
        // jump
        s = '0; s.id_jump = 1; step(s);
        // load-use on rt only when rt is read
        s = '0; s.ex_mem_read = 1; s.ex_rd = 5; s.id_rt = 5; s.id_use_rt = 1; step(s);
        s.id_use_rt = 0; step(s);
        // memory ready in request cycle: no stall
        s = '0; s.mem_req = 1; s.dmem_ready = 1; step(s);
        // memory ready 3 cycles after request
        s = '0; s.mem_req = 1; step(s); step(s); step(s);
        s.dmem_ready = 1; step(s);
        s = '0; step(s);
        // memory never ready: timeout and pulse
        s = '0; s.mem_req = 1; repeat (5) step(s);
        s = '0; step(s); step(s);
        // mul/div with a memory stall arising in its second cycle
        s = '0; s.ex_muldiv_start = 1; step(s);
        s = '0; step(s);
        s.mem_req = 1; step(s); step(s); step(s);
        s.dmem_ready = 1; step(s);
        s = '0; step(s);
        // plain mul/div
        s = '0; s.ex_muldiv_start = 1; step(s);
        s = '0; repeat (4) step(s);
        // reset in the middle of a mul/div
        s = '0; s.ex_muldiv_start = 1; step(s);
        s = '0; step(s);
        s.rst = 1; step(s);
        s = '0; step(s); step(s);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            s.rst             = ($urandom_range(0, 199) == 0);
            s.id_rs           = AW'($urandom_range(0, 3));
            s.id_rt           = AW'($urandom_range(0, 3));
            s.id_use_rt       = $urandom_range(0, 1) == 1;
            s.id_jump         = $urandom_range(0, 99) < 15;
            s.ex_mem_read     = $urandom_range(0, 99) < 30;
            s.ex_rd           = AW'($urandom_range(0, 3));
            s.ex_branch_taken = $urandom_range(0, 99) < 15;
            s.ex_muldiv_start = $urandom_range(0, 99) < 8;
            s.mem_req         = $urandom_range(0, 99) < 30;
            s.dmem_ready      = $urandom_range(0, 9) < 5;
            step(s);
        end
        // let the monitor drain, bounded
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
